// File: rtl/alu_pkg.sv
// Shared constants for the execute-stage ALU: data width and opcode encodings.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND = 4'b0010;
    localparam logic [OP_W-1:0] OP_OR  = 4'b0011;
    localparam logic [OP_W-1:0] OP_NOT = 4'b0100;
    localparam logic [OP_W-1:0] OP_SRA = 4'b1000;
    localparam logic [OP_W-1:0] OP_SLL = 4'b1001;
    localparam logic [OP_W-1:0] OP_SRL = 4'b1010;
    localparam logic [OP_W-1:0] OP_ROL = 4'b1100;
    localparam logic [OP_W-1:0] OP_ROR = 4'b1101;

    function automatic logic op_is_valid(input logic [OP_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT,
            OP_SRA, OP_SLL, OP_SRL, OP_ROL, OP_ROR: op_is_valid = 1'b1;
            default:                                op_is_valid = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_shift_unit.sv
// Combinational single-bit shift/rotate unit for the ALU's Op[3]=1 opcode group.
module alu_shift_unit
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [2:0]        i_op,
    output logic [DATA_W-1:0] o_result
);

    // Low three opcode bits are needed: ROL/ROR share Op[1:0] with SRA/SLL.
    always_comb begin
        o_result = i_a;
        case (i_op)
            OP_SRA[2:0]: o_result = {i_a[DATA_W-1], i_a[DATA_W-1:1]};
            OP_SLL[2:0]: o_result = {i_a[DATA_W-2:0], 1'b0};
            OP_SRL[2:0]: o_result = {1'b0, i_a[DATA_W-1:1]};
            OP_ROL[2:0]: o_result = {i_a[DATA_W-2:0], i_a[DATA_W-1]};
            OP_ROR[2:0]: o_result = {i_a[0], i_a[DATA_W-1:1]};
            default:     o_result = i_a;
        endcase
    end

endmodule

// File: rtl/alu_core.sv
// Registered 32-bit ALU: arithmetic/logic mux, shift unit, opcode decode and
// output registers for Out and its zero flag.
module alu_core
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [OP_W-1:0]   Op,
    output logic [DATA_W-1:0] Out,
    output logic              Zero
);

    logic [DATA_W-1:0] w_arith;
    logic [DATA_W-1:0] w_shift;
    logic [DATA_W-1:0] w_result;
    logic              w_valid;
    logic              w_load;

    logic [DATA_W-1:0] r_out;
    logic              r_zero;

    always_comb begin
        w_arith = '0;
        case (Op)
            OP_ADD:  w_arith = A + B;
            OP_SUB:  w_arith = A - B;
            OP_AND:  w_arith = A & B;
            OP_OR:   w_arith = A | B;
            OP_NOT:  w_arith = ~A;
            default: w_arith = '0;
        endcase
    end

    alu_shift_unit u_shift (
        .i_a      (A),
        .i_op     (Op[2:0]),
        .o_result (w_shift)
    );

    assign w_result = Op[3] ? w_shift : w_arith;
    assign w_valid  = op_is_valid(Op);
    // Undefined opcodes behave exactly like a disabled cycle.
    assign w_load   = enable && w_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out  <= '0;
            r_zero <= 1'b1;
        end else if (w_load) begin
            r_out  <= w_result;
            r_zero <= (w_result == '0);
        end
    end

    assign Out  = r_out;
    assign Zero = r_zero;

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: the driver queues the expected registered
// outputs for each edge, the monitor pops and compares just after that edge.
module tb_alu_core;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  Op;
    logic [31:0] Out;
    logic        Zero;

    typedef struct {
        logic [31:0] out;
        logic        zero;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_errors;

    localparam logic [31:0] TA = 32'h96F2_0BE5;
    localparam logic [31:0] TB = 32'hB4AC_2923;

    alu_core dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .A      (A),
        .B      (B),
        .Op     (Op),
        .Out    (Out),
        .Zero   (Zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expectation per edge, checked 1 time unit after it.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (Out !== e.out || Zero !== e.zero) begin
                n_errors++;
                $display("FAIL %s: got Out=%h Zero=%b, expected Out=%h Zero=%b",
                         e.name, Out, Zero, e.out, e.zero);
            end
        end
    end

    task automatic step(input logic rst, input logic en, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] op,
                        input logic [31:0] eo, input logic ez, input string nm);
        exp_t e;
        @(negedge clk);
        reset  = rst;
        enable = en;
        A      = a;
        B      = b;
        Op     = op;
        e.out  = eo;
        e.zero = ez;
        e.name = nm;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    // One enabled edge followed by one disabled edge that must hold the result.
    task automatic pulse(input logic [3:0] op, input logic [31:0] eo, input string nm);
        step(1'b0, 1'b1, TA, TB, op, eo, 1'b0, nm);
        step(1'b0, 1'b0, TA, TB, op, eo, 1'b0, {nm, "_hold"});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset  = 1'b0;
        enable = 1'b0;
        A      = '0;
        B      = '0;
        Op     = '0;

        step(1'b1, 1'b0, TA, TB, 4'b0000, 32'h0, 1'b1, "reset1");
        step(1'b1, 1'b0, TA, TB, 4'b0000, 32'h0, 1'b1, "reset2");
        step(1'b1, 1'b1, TA, TB, 4'b0000, 32'h0, 1'b1, "reset_over_enable");
        step(1'b0, 1'b0, TA, TB, 4'b0000, 32'h0, 1'b1, "idle_after_reset");

        pulse(4'b0000, 32'h4B9E_3508, "add");
        pulse(4'b0001, 32'hE245_E2C2, "sub");
        pulse(4'b0010, 32'h94A0_0921, "and");
        pulse(4'b0011, 32'hB6FE_2BE7, "or");
        pulse(4'b0100, 32'h690D_F41A, "not");
        pulse(4'b1000, 32'hCB79_05F2, "sra");
        pulse(4'b1001, 32'h2DE4_17CA, "sll");
        pulse(4'b1010, 32'h4B79_05F2, "srl");
        pulse(4'b1100, 32'h2DE4_17CB, "rol");
        pulse(4'b1101, 32'hCB79_05F2, "ror");

        step(1'b0, 1'b1, 32'h1234_5678, 32'h1234_5678, 4'b0001, 32'h0, 1'b1, "zero_sub");
        step(1'b0, 1'b1, 32'h1234_5678, 32'h1234_5678, 4'b0000, 32'h2468_ACF0, 1'b0, "zero_then_add");

        step(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0001, 32'h2468_ACF0, 1'b0, "hold1");
        step(1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0100, 32'h2468_ACF0, 1'b0, "hold2");
        step(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D, 4'b1001, 32'h2468_ACF0, 1'b0, "hold3");
        step(1'b0, 1'b1, TA, TB, 4'b1111, 32'h2468_ACF0, 1'b0, "undef_1111");
        step(1'b0, 1'b1, TA, TB, 4'b0101, 32'h2468_ACF0, 1'b0, "undef_0101");
        step(1'b0, 1'b1, TA, TB, 4'b1011, 32'h2468_ACF0, 1'b0, "undef_1011");

        step(1'b0, 1'b1, TA, TB, 4'b0010, 32'h94A0_0921, 1'b0, "b2b_and");
        step(1'b0, 1'b1, TA, TB, 4'b0011, 32'hB6FE_2BE7, 1'b0, "b2b_or");
        step(1'b0, 1'b1, TA, TB, 4'b0100, 32'h690D_F41A, 1'b0, "b2b_not");
        step(1'b0, 1'b0, TA, TB, 4'b0000, 32'h690D_F41A, 1'b0, "b2b_hold");

        step(1'b1, 1'b1, TA, TB, 4'b0000, 32'h0, 1'b1, "final_reset");

        #2;
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
